// File: rtl/bus_master_port.sv
// Initiator agent for one master slot of the backplane arbiter: takes a single
// read/write command, runs the BARQ/BAGD/target-ready/strobe handshake, returns one response.
module bus_master_port #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int GRANT_TIMEOUT = 64,
    parameter int GAP_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [1:0]        rsp_err_o,
    output logic              barq_o,
    input  logic              bagd_i,
    input  logic              target_ready_i,
    input  logic              data_strobe_i,
    input  logic              error_i,
    output logic              bus_oe_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_we_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);
    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_LOST    = 2'b11;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_TR, XFER, RESP, GAP} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  grant_cnt, grant_cnt_next;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_next;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              accept;
    logic              driving_next;
    logic [1:0]        err_next;
    logic [DATA_W-1:0] rdata_next;

    always_comb begin
        state_next     = state;
        grant_cnt_next = grant_cnt;
        gap_cnt_next   = gap_cnt;
        err_next       = rsp_err_o;
        rdata_next     = rsp_rdata_o;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    accept         = 1'b1;
                    state_next     = REQ;
                    grant_cnt_next = '0;
                end
            end
            REQ: begin
                if (bagd_i) begin
                    state_next = WAIT_TR;
                end else if (grant_cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    state_next = RESP;
                    err_next   = ERR_TIMEOUT;
                    rdata_next = '0;
                end else begin
                    grant_cnt_next = grant_cnt + CNT_W'(1);
                end
            end
            WAIT_TR: begin
                if (error_i) begin
                    state_next = RESP;
                    err_next   = ERR_BUS;
                    rdata_next = '0;
                end else if (!bagd_i) begin
                    state_next = RESP;
                    err_next   = ERR_LOST;
                    rdata_next = '0;
                end else if (target_ready_i) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                // error outranks strobe, strobe outranks a dropped grant
                if (error_i) begin
                    state_next = RESP;
                    err_next   = ERR_BUS;
                    rdata_next = '0;
                end else if (data_strobe_i) begin
                    state_next = RESP;
                    err_next   = ERR_OK;
                    rdata_next = cmd_we_q ? '0 : bus_rdata_i;
                end else if (!bagd_i) begin
                    state_next = RESP;
                    err_next   = ERR_LOST;
                    rdata_next = '0;
                end
            end
            RESP: begin
                state_next   = GAP;
                gap_cnt_next = '0;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign driving_next = (state_next == WAIT_TR) || (state_next == XFER);

    // All outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_cnt   <= '0;
            gap_cnt     <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_ready_o <= 1'b0;
            barq_o      <= 1'b0;
            bus_oe_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= '0;
            rsp_rdata_o <= '0;
        end else begin
            state     <= state_next;
            grant_cnt <= grant_cnt_next;
            gap_cnt   <= gap_cnt_next;
            if (accept) begin
                cmd_we_q    <= cmd_we_i;
                cmd_addr_q  <= cmd_addr_i;
                cmd_wdata_q <= cmd_wdata_i;
            end
            cmd_ready_o <= (state_next == IDLE);
            barq_o      <= (state_next == REQ) || driving_next;
            bus_oe_o    <= driving_next;
            bus_we_o    <= driving_next && cmd_we_q;
            if (state == REQ && state_next == WAIT_TR) begin
                bus_addr_o  <= cmd_addr_q;
                bus_wdata_o <= cmd_wdata_q;
            end
            rsp_valid_o <= (state_next == RESP);
            rsp_err_o   <= err_next;
            rsp_rdata_o <= rdata_next;
        end
    end
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: transaction-level reference model compared every cycle,
// directed handshake scenarios with literal expectations, then randomized traffic.
module tb_bus_master_port;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int GT     = 8;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              barq, bagd, target_ready, data_strobe, bus_error;
    logic              bus_oe, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRANT_TIMEOUT(GT), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .barq_o(barq), .bagd_i(bagd), .target_ready_i(target_ready),
        .data_strobe_i(data_strobe), .error_i(bus_error),
        .bus_oe_o(bus_oe), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_we_o(bus_we), .bus_rdata_i(bus_rdata)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit              live = 1'b0;
    bit              exp_ready, exp_barq, exp_oe, exp_we, exp_valid;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_rdata;
    logic [1:0]        exp_err;

    task automatic clear_exp();
        exp_ready = 0; exp_barq = 0; exp_oe = 0; exp_we = 0; exp_valid = 0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_err = '0;
    endtask

    task automatic clk_edge(output bit r);
        @(posedge clk);
        r = rst;
        if (r) begin
            clear_exp();
            live = 1'b1;
        end
    endtask

    task automatic complete(input logic [1:0] err, input logic [DATA_W-1:0] rdata);
        exp_barq = 0; exp_oe = 0; exp_we = 0;
        exp_valid = 1; exp_err = err; exp_rdata = rdata;
    endtask

    initial begin : model
        bit r, accepted, granted, tr_seen, was_ready;
        int waited;
        logic m_we;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wdata;
        clear_exp();
        forever begin
            accepted = 0;
            while (!accepted) begin
                was_ready = exp_ready;
                clk_edge(r);
                if (r) continue;
                if (was_ready && cmd_valid) begin
                    accepted = 1;
                    m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata;
                    exp_ready = 0; exp_barq = 1;
                end else begin
                    exp_ready = 1;
                end
            end
            granted = 0;
            waited  = 0;
            while (1) begin
                clk_edge(r);
                if (r) break;
                if (bagd) begin
                    granted = 1;
                    exp_oe = 1; exp_we = m_we; exp_addr = m_addr; exp_wdata = m_wdata;
                    break;
                end
                waited++;
                if (waited == GT) begin
                    complete(2'b10, '0);
                    break;
                end
            end
            if (r) continue;
            if (granted) begin
                tr_seen = 0;
                while (1) begin
                    clk_edge(r);
                    if (r) break;
                    if (bus_error) begin complete(2'b01, '0); break; end
                    if (tr_seen && data_strobe) begin
                        complete(2'b00, m_we ? '0 : bus_rdata);
                        break;
                    end
                    if (!bagd) begin complete(2'b11, '0); break; end
                    if (target_ready) tr_seen = 1;
                end
                if (r) continue;
            end
            clk_edge(r);
            if (r) continue;
            exp_valid = 0;
            for (int g = 1; g < GAP; g++) begin
                clk_edge(r);
                if (r) break;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("barq",      32'(barq),      32'(exp_barq));
            chk("bus_oe",    32'(bus_oe),    32'(exp_oe));
            chk("bus_we",    32'(bus_we),    32'(exp_we));
            chk("bus_addr",  32'(bus_addr),  32'(exp_addr));
            chk("bus_wdata", 32'(bus_wdata), 32'(exp_wdata));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("rsp_err",   32'(rsp_err),   32'(exp_err));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("issue_ready", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input string name);
        int t;
        t = 0;
        while (!rsp_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(rsp_valid), 1);
    endtask

    initial begin : stim
        int hi, low, t;
        rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
        bagd = 0; target_ready = 0; data_strobe = 0; bus_error = 0; bus_rdata = '0;
        step(3);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_barq",  32'(barq), 0);
        rst = 0;
        step(1);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        // read: strobe with 0xBEEF
        issue(1'b0, 16'h0012, 16'h0000);
        step(2); bagd = 1;
        step(1); target_ready = 1;
        step(1); target_ready = 0;
        step(2); data_strobe = 1; bus_rdata = 16'hBEEF;
        step(1); data_strobe = 0; bagd = 0;
        chk("read_valid", 32'(rsp_valid), 1);
        chk("read_rdata", 32'(rsp_rdata), 32'h0000BEEF);
        chk("read_err",   32'(rsp_err), 0);
        chk("read_barq",  32'(barq), 0);
        step(2);
        chk("read_gap_ready", 32'(cmd_ready), 0);
        chk("read_rdata_held", 32'(rsp_rdata), 32'h0000BEEF);
        step(1);
        chk("read_ready_back", 32'(cmd_ready), 1);

        // write
        issue(1'b1, 16'h0034, 16'h5A5A);
        bagd = 1;
        step(1);
        chk("write_oe",    32'(bus_oe), 1);
        chk("write_we",    32'(bus_we), 1);
        chk("write_wdata", 32'(bus_wdata), 32'h00005A5A);
        chk("write_addr",  32'(bus_addr), 32'h00000034);
        target_ready = 1; step(1); target_ready = 0; step(1);
        chk("write_xfer_oe", 32'(bus_oe), 1);
        bus_rdata = 16'h1234; data_strobe = 1;
        step(1); data_strobe = 0; bagd = 0;
        chk("write_valid", 32'(rsp_valid), 1);
        chk("write_err",   32'(rsp_err), 0);
        chk("write_rdata", 32'(rsp_rdata), 0);
        chk("write_oe_off", 32'(bus_oe), 0);
        chk("write_wdata_hold", 32'(bus_wdata), 32'h00005A5A);
        step(3);

        // bus error alone, then error together with strobe
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, 16'h0040, 16'h0000);
            bagd = 1; step(1);
            target_ready = 1; step(1); target_ready = 0;
            bus_error = 1; data_strobe = (k == 1);
            step(1); bus_error = 0; data_strobe = 0; bagd = 0;
            chk("buserr_valid", 32'(rsp_valid), 1);
            chk("buserr_err",   32'(rsp_err), 1);
            step(3);
        end

        // grant timeout
        issue(1'b0, 16'h0100, 16'h0000);
        hi = 0; t = 0;
        while (!rsp_valid && t < 40) begin
            if (barq) hi++;
            @(negedge clk);
            t++;
        end
        chk("timeout_valid", 32'(rsp_valid), 1);
        chk("timeout_barq_cycles", 32'(hi), 8);
        chk("timeout_err", 32'(rsp_err), 2);
        step(3);

        // grant lost in XFER
        issue(1'b1, 16'h0200, 16'h0F0F);
        bagd = 1; step(1);
        target_ready = 1; step(1); target_ready = 0; step(1);
        bagd = 0; step(1);
        chk("lost_valid", 32'(rsp_valid), 1);
        chk("lost_err",   32'(rsp_err), 3);
        chk("lost_oe",    32'(bus_oe), 0);
        step(3);

        // reset during XFER
        issue(1'b0, 16'h0300, 16'h0000);
        bagd = 1; step(1);
        target_ready = 1; step(1); target_ready = 0; step(1);
        rst = 1; step(1);
        chk("midrst_barq",  32'(barq), 0);
        chk("midrst_oe",    32'(bus_oe), 0);
        chk("midrst_ready", 32'(cmd_ready), 0);
        chk("midrst_valid", 32'(rsp_valid), 0);
        rst = 0; bagd = 0;
        step(4);

        // back-to-back: count low barq cycles between the two requests
        issue(1'b0, 16'h0400, 16'h0000);
        bagd = 1; step(1);
        target_ready = 1; step(1); target_ready = 0;
        data_strobe = 1; step(1); data_strobe = 0; bagd = 0;
        wait_rsp("b2b_rsp");
        cmd_valid = 1; cmd_we = 0; cmd_addr = 16'h0401;
        low = 0; t = 0;
        while (!barq && t < 20) begin
            low++;
            @(negedge clk);
            t++;
        end
        cmd_valid = 0;
        chk("b2b_low_cycles", 32'(low), 32'(GAP + 2));
        wait_rsp("b2b_second_rsp");
        step(4);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cmd_valid    = ($urandom_range(0, 3) == 0);
            cmd_we       = 1'($urandom_range(0, 1));
            cmd_addr     = 16'($urandom);
            cmd_wdata    = 16'($urandom);
            bagd         = ($urandom_range(0, 9) < 8);
            target_ready = ($urandom_range(0, 1) == 0);
            data_strobe  = ($urandom_range(0, 9) < 3);
            bus_error    = ($urandom_range(0, 24) == 0);
            bus_rdata    = 16'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 0; cmd_valid = 0; bagd = 0; target_ready = 0; data_strobe = 0; bus_error = 0;
        step(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
